reg_scoreboard: RTL

Parametrised register scoreboard for the ID stage of the pipelined CPU. It generalises the load-use hazard check to per-register countdown tracking with variable result latency. This supports multi-cycle units such as load, multiply and divide alongside single-cycle ALU ops. It produces the ID-stage stall (PC/IF-ID hold plus ID/EX bubble), covering RAW, WAW and fence hazards, and tracks which architectural registers have writes in flight.

---
 rtl/reg_scoreboard.sv | 68 ++++++
 1 files changed

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register latency countdown scoreboard for ID-stage hazard stalls
module reg_scoreboard #(
  parameter int NREG = 32,
  parameter int RW   = 5,
  parameter int LW   = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic [RW-1:0]   issue_rs,
  input  logic            issue_rs_used,
  input  logic [RW-1:0]   issue_rt,
  input  logic            issue_rt_used,
  input  logic [RW-1:0]   issue_rd,
  input  logic            issue_wr,
  input  logic [LW-1:0]   issue_lat,
  input  logic            issue_fence,
  input  logic            flush,
  output logic            stall,
  output logic            issue_fire,
  output logic [NREG-1:0] pending_mask,
  output logic [RW:0]     busy_count,
  output logic            idle
);

  logic [LW-1:0] cnt [NREG];
  logic [LW-1:0] effLat;
  logic          rsHaz, rtHaz, rawHaz, wawHaz, fenceHaz;
  logic          loadEn;

  assign effLat = (issue_lat == '0) ? LW'(1) : issue_lat;

  // A counter at 1 is covered by the bypass network, so only >= 2 blocks a reader.
  assign rsHaz  = issue_rs_used && (issue_rs != '0) && (cnt[issue_rs] > LW'(1));
  assign rtHaz  = issue_rt_used && (issue_rt != '0) && (cnt[issue_rt] > LW'(1));
  assign rawHaz = rsHaz || rtHaz;

  // Older write must not retire after the younger one.
  assign wawHaz   = issue_wr && (issue_rd != '0) && (cnt[issue_rd] > effLat);
  assign fenceHaz = issue_fence && (|pending_mask);

  assign stall      = issue_valid && !flush && (rawHaz || wawHaz || fenceHaz);
  assign issue_fire = issue_valid && !stall && !flush;
  assign loadEn     = issue_fire && issue_wr && (issue_rd != '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (loadEn && (issue_rd == RW'(r))) cnt[r] <= effLat;
        else if (cnt[r] != '0)              cnt[r] <= cnt[r] - LW'(1);
      end
    end
  end

  always_comb begin
    pending_mask = '0;
    busy_count   = '0;
    for (int r = 0; r < NREG; r++) begin
      pending_mask[r] = (cnt[r] != '0);
      busy_count      = busy_count + (RW+1)'(pending_mask[r]);
    end
  end

  assign idle = (busy_count == '0);

endmodule
